// File: rtl/datapath.sv
// Goldschmidt division datapath: one iteration step per clock on a single
// shared 16x16 unsigned multiplier. All values are unsigned Q2.14.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset; clears regN, regD, regK
//   sel_K_mux  - multiplier K operand: 0 = IA, 1 = regK
//   sel_ND_mux - multiplier A operand: 00 = N, 01 = D, 10 = regN, 11 = regD;
//                bit 0 also picks the destination (0 = regN, 1 = regD/regK)
//   N, D, IA   - numerator, divisor, initial reciprocal approximation
//   result     - current quotient estimate (regN)
module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_K_mux,
  input  logic [1:0]  sel_ND_mux,
  input  logic [15:0] N,
  input  logic [15:0] D,
  input  logic [15:0] IA,
  output logic [15:0] result
);

  logic [15:0] reg_n;
  logic [15:0] reg_d;
  logic [15:0] reg_k;

  logic [15:0] op_a;
  logic [15:0] op_k;
  logic [31:0] prod;
  logic [15:0] p;
  logic [15:0] k_next;

  always_comb begin
    op_k = sel_K_mux ? reg_k : IA;
    op_a = N;
    case (sel_ND_mux)
      2'b00:   op_a = N;
      2'b01:   op_a = D;
      2'b10:   op_a = reg_n;
      default: op_a = reg_d;
    endcase
  end

  // Q2.14 x Q2.14 = Q4.28; keep bits [29:14] and saturate when the integer
  // part overflows the two available integer bits.
  always_comb begin
    prod   = 32'(op_a) * 32'(op_k);
    p      = (|prod[31:30]) ? '1 : prod[29:14];
    // 2.0 - P, clamped at zero: P >= 2.0 exactly when its MSB is set.
    k_next = p[15] ? '0 : 16'h8000 - p;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_n <= '0;
      reg_d <= '0;
      reg_k <= '0;
    end else if (sel_ND_mux[0]) begin
      reg_d <= p;
      reg_k <= k_next;
    end else begin
      reg_n <= p;
    end
  end

  assign result = reg_n;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: a driver applies one select/operand set per
// cycle, updates a plain-arithmetic reference model and queues the expected
// result; a monitor pops and compares on every falling edge.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_K_mux;
  logic [1:0]  sel_ND_mux;
  logic [15:0] N;
  logic [15:0] D;
  logic [15:0] IA;
  logic [15:0] result;

  int checks = 0;
  int passed = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  // Reference model state, kept as real Q2.14 magnitudes in plain integers.
  int unsigned m_n = 0;
  int unsigned m_d = 0;
  int unsigned m_k = 0;

  datapath dut (
    .clk        (clk),
    .reset      (reset),
    .sel_K_mux  (sel_K_mux),
    .sel_ND_mux (sel_ND_mux),
    .N          (N),
    .D          (D),
    .IA         (IA),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Fixed-point product: value(a)*value(k) in Q2.14, truncated, capped at
  // 0xFFFF when the true product is 4.0 or more.
  function automatic int unsigned qmul(input int unsigned a, input int unsigned k);
    longint unsigned pr;
    pr = longint'(a) * longint'(k);
    if (pr >= 64'd1073741824) return 32'hFFFF;
    return int'(pr / 64'd16384);
  endfunction

  task automatic expect_val(input string nm, input int unsigned v);
    exp_q.push_back(v[15:0]);
    name_q.push_back(nm);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input string nm, input bit sk, input bit [1:0] snd,
                      input int unsigned nn, input int unsigned dd,
                      input int unsigned ii);
    int unsigned a, k, p;
    sel_K_mux  = sk;
    sel_ND_mux = snd;
    N  = nn[15:0];
    D  = dd[15:0];
    IA = ii[15:0];
    case (snd)
      2'd0:    a = nn;
      2'd1:    a = dd;
      2'd2:    a = m_n;
      default: a = m_d;
    endcase
    k = sk ? m_k : ii;
    p = qmul(a, k);
    if (snd == 2'd1 || snd == 2'd3) begin
      m_d = p;
      m_k = (p >= 32'h8000) ? 0 : 32'h8000 - p;
    end else begin
      m_n = p;
    end
    @(posedge clk);
    #1;
    expect_val(nm, m_n);
    @(negedge clk);
  endtask

  // Exposes regK on result: 1.0 * regK == regK.
  task automatic probe_k(input string nm);
    step(nm, 1'b1, 2'd0, 32'h4000, 32'h0, 32'h0);
  endtask

  // Called just after a falling edge; asserts reset mid-cycle.
  task automatic do_reset(input string nm);
    #2;
    reset = 1'b0;
    m_n = 0;
    m_d = 0;
    m_k = 0;
    expect_val(nm, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (result === e) passed++;
      else $display("FAIL %s: result=%h expected %h", nm, result, e);
    end
  end

  initial begin
    reset      = 1'b0;
    sel_K_mux  = 1'b0;
    sel_ND_mux = 2'd0;
    N  = '0;
    D  = '0;
    IA = '0;
    expect_val("reset_init", 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    probe_k("reset_init_k");

    // Identity: 0.5 / 1.0 with exact reciprocal
    step("id_nia",  1'b0, 2'd0, 32'h2000, 32'h4000, 32'h4000);
    step("id_dia",  1'b0, 2'd1, 32'h2000, 32'h4000, 32'h4000);
    step("id_nk",   1'b1, 2'd2, 32'h2000, 32'h4000, 32'h4000);
    step("id_dk",   1'b1, 2'd3, 32'h2000, 32'h4000, 32'h4000);
    probe_k("id_k");

    // Division: 0.75 / 1.5 with IA ~ 2/3
    step("div_nia", 1'b0, 2'd0, 32'h3000, 32'h6000, 32'h2AAA);
    step("div_dia", 1'b0, 2'd1, 32'h3000, 32'h6000, 32'h2AAA);
    step("div_nk",  1'b1, 2'd2, 32'h3000, 32'h6000, 32'h2AAA);
    step("div_dk",  1'b1, 2'd3, 32'h3000, 32'h6000, 32'h2AAA);
    step("div_nk2", 1'b1, 2'd2, 32'h3000, 32'h6000, 32'h2AAA);

    // Saturation and K clamp
    step("sat",     1'b0, 2'd0, 32'hFFFF, 32'h1234, 32'hFFFF);
    step("kclamp",  1'b0, 2'd1, 32'h1234, 32'hFFFF, 32'hFFFF);
    probe_k("kclamp_k");
    step("kedge",   1'b0, 2'd1, 32'h0, 32'h8000, 32'h4000);
    probe_k("kedge_k");

    // Mid-sequence reset discards everything including regK
    step("pre_rst_n", 1'b0, 2'd0, 32'h3000, 32'h6000, 32'h2AAA);
    step("pre_rst_d", 1'b0, 2'd1, 32'h3000, 32'h6000, 32'h2AAA);
    do_reset("rst_mid");
    probe_k("rst_mid_k");
    step("rst_mid_dk", 1'b0, 2'd3, 32'h0, 32'h0, 32'h4000);

    // Random Goldschmidt sequences and arbitrary select mixes
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_reset("rand_rst");
      end else if (r < 30) begin
        int unsigned nn, dd, ii;
        nn = $urandom_range(0, 32'hFFFF);
        dd = $urandom_range(32'h4000, 32'h7FFF);
        ii = 32'h1000_0000 / dd;
        step("gs_nia", 1'b0, 2'd0, nn, dd, ii);
        step("gs_dia", 1'b0, 2'd1, nn, dd, ii);
        for (int j = 0; j < 3; j++) begin
          step("gs_nk", 1'b1, 2'd2, nn, dd, ii);
          step("gs_dk", 1'b1, 2'd3, nn, dd, ii);
        end
      end else begin
        step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF),
             $urandom_range(0, 32'hFFFF));
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
